// File: rtl/isa_defs.sv
// Shared ISA definitions for the 8-bit core. These are the opcodes, the ALU command codes,
// the decode-state encoding and a decode helper that maps each opcode to its control bits.
package isa_defs;

  localparam int REG_W_DEF = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_MOV = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3,
    OP_AND  = 4'd4,  OP_OR  = 4'd5,  OP_NOT = 4'd6,  OP_IN  = 4'd7,
    OP_OUT  = 4'd8,  OP_LD  = 4'd9,  OP_ST  = 4'd10, OP_LDM = 4'd11,
    OP_ADDI = 4'd12, OP_LDD = 4'd13, OP_STD = 4'd14, OP_RSV = 4'd15
  } opcode_e;

  typedef enum logic [3:0] {
    CMD_PASS_B = 4'd0, CMD_ADD = 4'd1, CMD_SUB = 4'd2, CMD_AND = 4'd3,
    CMD_OR     = 4'd4, CMD_NOT_A = 4'd5, CMD_PASS_A = 4'd6
  } exe_cmd_e;

  typedef enum logic {ST_DECODE = 1'b0, ST_IMM = 1'b1} state_e;

  typedef struct packed {
    logic     act;       // a real instruction; NOP and reserved are bubbles
    logic     wb_en;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     s;
    logic     in_port;
    logic     out_port;
    logic     imm;
    logic     rd_ra;     // ra is actually read, for load-use detection
    logic     rd_rb;
    exe_cmd_e cmd;
  } ctrl_t;

  function automatic logic is_two_word(input opcode_e op);
    return (op == OP_LDM) || (op == OP_ADDI) || (op == OP_LDD) || (op == OP_STD);
  endfunction

  function automatic ctrl_t decode(input opcode_e op);
    ctrl_t c;
    c = '0;
    c.cmd = CMD_PASS_B;
    c.act = 1'b1;
    case (op)
      OP_MOV:  begin c.wb_en = 1'b1; c.rd_rb = 1'b1; end
      OP_ADD:  begin c.wb_en = 1'b1; c.s = 1'b1; c.rd_ra = 1'b1; c.rd_rb = 1'b1; c.cmd = CMD_ADD; end
      OP_SUB:  begin c.wb_en = 1'b1; c.s = 1'b1; c.rd_ra = 1'b1; c.rd_rb = 1'b1; c.cmd = CMD_SUB; end
      OP_AND:  begin c.wb_en = 1'b1; c.s = 1'b1; c.rd_ra = 1'b1; c.rd_rb = 1'b1; c.cmd = CMD_AND; end
      OP_OR:   begin c.wb_en = 1'b1; c.s = 1'b1; c.rd_ra = 1'b1; c.rd_rb = 1'b1; c.cmd = CMD_OR; end
      OP_NOT:  begin c.wb_en = 1'b1; c.s = 1'b1; c.rd_ra = 1'b1; c.cmd = CMD_NOT_A; end
      OP_IN:   begin c.wb_en = 1'b1; c.in_port = 1'b1; end
      OP_OUT:  begin c.out_port = 1'b1; c.rd_rb = 1'b1; end
      OP_LD:   begin c.wb_en = 1'b1; c.mem_r_en = 1'b1; c.rd_rb = 1'b1; end
      // Store address comes from ra through the ALU, data from rb.
      OP_ST:   begin c.mem_w_en = 1'b1; c.rd_ra = 1'b1; c.rd_rb = 1'b1; c.cmd = CMD_PASS_A; end
      OP_LDM:  begin c.wb_en = 1'b1; c.imm = 1'b1; end
      OP_ADDI: begin c.wb_en = 1'b1; c.s = 1'b1; c.imm = 1'b1; c.rd_ra = 1'b1; c.cmd = CMD_ADD; end
      OP_LDD:  begin c.wb_en = 1'b1; c.mem_r_en = 1'b1; c.imm = 1'b1; end
      OP_STD:  begin c.mem_w_en = 1'b1; c.imm = 1'b1; c.rd_rb = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 4-entry architectural register file with one write port and two asynchronous read ports.
// When ID_WB_BYPASS_EN is defined, a read of the register being written returns the new value.
module reg_file
  import isa_defs::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [REG_W-1:0] wdata,
  input  logic [1:0]       raddr_a,
  input  logic [1:0]       raddr_b,
  output logic [REG_W-1:0] rdata_a,
  output logic [REG_W-1:0] rdata_b
);

  logic [REG_W-1:0] regs_q [4];
  logic [REG_W-1:0] regs_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

`ifdef ID_WB_BYPASS_EN
  assign rdata_a = (we && waddr == raddr_a) ? wdata : regs_q[raddr_a];
  assign rdata_b = (we && waddr == raddr_b) ? wdata : regs_q[raddr_b];
`else
  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
`endif

endmodule

// File: rtl/id_stage.sv
// Decode stage. It decodes the fetched word, sequences two-word immediates and detects
// load-use hazards. Write-through register reads are selected by ID_WB_BYPASS_EN.
module id_stage
  import isa_defs::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       instr,
  input  logic             instr_valid,
  input  logic [REG_W-1:0] in_port,
  input  logic             WB_WB_EN,
  input  logic [1:0]       WB_Dest,
  input  logic [REG_W-1:0] WB_Value,
  input  logic             EXE_MEM_R_EN,
  input  logic [1:0]       EXE_Dest,
  output logic             WB_EN,
  output logic             MEM_R_EN,
  output logic             MEM_W_EN,
  output logic             S,
  output logic             inPort,
  output logic             outPort,
  output logic             imm,
  output logic [3:0]       EXE_CMD,
  output logic [REG_W-1:0] Val_Ra,
  output logic [REG_W-1:0] Val_Rb,
  output logic [REG_W-1:0] Val_Imm,
  output logic [1:0]       Dest,
  output logic [1:0]       src1,
  output logic [1:0]       src2,
  output logic             stall
);

  state_e           state_q, state_d;
  opcode_e          hold_op_q, hold_op_d;
  logic [1:0]       hold_ra_q, hold_ra_d;
  logic [1:0]       hold_rb_q, hold_rb_d;

  opcode_e          cur_op;
  logic [1:0]       cur_ra, cur_rb;
  ctrl_t            ctrl;
  logic             hazard, emit;
  logic [REG_W-1:0] rd_a, rd_b;

  // In IMM the operand fields come from the hold registers, not the immediate word.
  always_comb begin
    if (state_q == ST_IMM) begin
      cur_op = hold_op_q;
      cur_ra = hold_ra_q;
      cur_rb = hold_rb_q;
    end else begin
      cur_op = opcode_e'(instr[7:4]);
      cur_ra = instr[3:2];
      cur_rb = instr[1:0];
    end
    ctrl   = decode(cur_op);
    hazard = EXE_MEM_R_EN && ((ctrl.rd_ra && EXE_Dest == cur_ra) ||
                              (ctrl.rd_rb && EXE_Dest == cur_rb));
  end

  reg_file #(.REG_W(REG_W)) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .we      (WB_WB_EN),
    .waddr   (WB_Dest),
    .wdata   (WB_Value),
    .raddr_a (cur_ra),
    .raddr_b (cur_rb),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  always_comb begin
    state_d   = state_q;
    hold_op_d = hold_op_q;
    hold_ra_d = hold_ra_q;
    hold_rb_d = hold_rb_q;
    emit      = 1'b0;
    stall     = 1'b0;
    case (state_q)
      ST_DECODE: begin
        if (instr_valid) begin
          if (hazard) begin
            stall = 1'b1;
          end else if (is_two_word(cur_op)) begin
            hold_op_d = cur_op;
            hold_ra_d = cur_ra;
            hold_rb_d = cur_rb;
            state_d   = ST_IMM;
          end else begin
            emit = ctrl.act;
          end
        end
      end
      ST_IMM: begin
        if (instr_valid) begin
          emit    = 1'b1;
          state_d = ST_DECODE;
        end
      end
      default: state_d = ST_DECODE;
    endcase
    if (rst) begin
      emit  = 1'b0;
      stall = 1'b0;
    end
  end

  always_comb begin
    WB_EN    = 1'b0;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    S        = 1'b0;
    inPort   = 1'b0;
    outPort  = 1'b0;
    imm      = 1'b0;
    EXE_CMD  = 4'd0;
    Val_Ra   = '0;
    Val_Rb   = '0;
    Val_Imm  = '0;
    Dest     = 2'd0;
    src1     = 2'd0;
    src2     = 2'd0;
    if (emit) begin
      WB_EN    = ctrl.wb_en;
      MEM_R_EN = ctrl.mem_r_en;
      MEM_W_EN = ctrl.mem_w_en;
      S        = ctrl.s;
      inPort   = ctrl.in_port;
      outPort  = ctrl.out_port;
      imm      = ctrl.imm;
      EXE_CMD  = ctrl.cmd;
      Val_Ra   = rd_a;
      Val_Rb   = ctrl.in_port ? in_port : rd_b;
      Val_Imm  = (state_q == ST_IMM) ? REG_W'(instr) : '0;
      Dest     = ctrl.wb_en ? cur_ra : 2'd0;
      src1     = cur_ra;
      src2     = cur_rb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DECODE;
      hold_op_q <= OP_NOP;
      hold_ra_q <= 2'd0;
      hold_rb_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      hold_op_q <= hold_op_d;
      hold_ra_q <= hold_ra_d;
      hold_rb_q <= hold_rb_d;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage; ID_WB_BYPASS_EN selects the expected same-cycle read value.
module tb_id_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr, in_port, WB_Value;
  logic       instr_valid, WB_WB_EN, EXE_MEM_R_EN;
  logic [1:0] WB_Dest, EXE_Dest;
  logic       WB_EN, MEM_R_EN, MEM_W_EN, S, inPort, outPort, imm, stall;
  logic [3:0] EXE_CMD;
  logic [7:0] Val_Ra, Val_Rb, Val_Imm;
  logic [1:0] Dest, src1, src2;

  int n_cmp = 0;
  int n_mis = 0;

  wire [41:0] obs = {WB_EN, MEM_R_EN, MEM_W_EN, S, inPort, outPort, imm, EXE_CMD,
                     Val_Ra, Val_Rb, Val_Imm, Dest, src1, src2, stall};

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .in_port(in_port),
    .WB_WB_EN(WB_WB_EN), .WB_Dest(WB_Dest), .WB_Value(WB_Value),
    .EXE_MEM_R_EN(EXE_MEM_R_EN), .EXE_Dest(EXE_Dest),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .S(S), .inPort(inPort),
    .outPort(outPort), .imm(imm), .EXE_CMD(EXE_CMD), .Val_Ra(Val_Ra), .Val_Rb(Val_Rb),
    .Val_Imm(Val_Imm), .Dest(Dest), .src1(src1), .src2(src2), .stall(stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = 8'h25; instr_valid = 1'b1;
    @(negedge clk);
    if (obs !== 42'd0) begin n_mis++; $display("FAIL reset_bubble got %h exp 0", obs); end
    n_cmp++;
    tick();
    rst = 1'b0; instr_valid = 1'b0;
    $display("reset: outputs %h", obs);
  endtask

  task automatic test_alu();
    WB_WB_EN = 1'b1; WB_Dest = 2'd1; WB_Value = 8'h05;
    tick();
    WB_WB_EN = 1'b0; instr = 8'h25; instr_valid = 1'b1;   // ADD R1,R1
    @(negedge clk);
    if (EXE_CMD !== 4'd1) begin n_mis++; $display("FAIL add_cmd got %0d exp 1", EXE_CMD); end
    n_cmp++;
    if (Val_Ra !== 8'h05 || Val_Rb !== 8'h05) begin
      n_mis++; $display("FAIL add_vals got %h/%h exp 05/05", Val_Ra, Val_Rb);
    end
    n_cmp++;
    if ({WB_EN, S, Dest, stall} !== {1'b1, 1'b1, 2'd1, 1'b0}) begin
      n_mis++; $display("FAIL add_ctrl got %b%b %0d %b exp 11 1 0", WB_EN, S, Dest, stall);
    end
    n_cmp++;
    $display("ADD R1,R1: cmd=%0d ra=%h rb=%h", EXE_CMD, Val_Ra, Val_Rb);
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_two_word();
    instr = 8'hB8; instr_valid = 1'b1;                    // LDM R2
    @(negedge clk);
    if (obs !== 42'd0) begin n_mis++; $display("FAIL ldm_first_bubble got %h exp 0", obs); end
    n_cmp++;
    tick();
    instr = 8'hA7;
    @(negedge clk);
    if ({imm, Val_Imm, Dest, WB_EN, EXE_CMD} !== {1'b1, 8'hA7, 2'd2, 1'b1, 4'd0}) begin
      n_mis++; $display("FAIL ldm_emit got imm=%b v=%h d=%0d wb=%b cmd=%0d exp 1 a7 2 1 0",
                        imm, Val_Imm, Dest, WB_EN, EXE_CMD);
    end
    n_cmp++;
    $display("LDM R2,0xA7: imm=%b Val_Imm=%h", imm, Val_Imm);
    tick();
    instr = 8'hB8;
    tick();
    instr_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (obs !== 42'd0) begin n_mis++; $display("FAIL ldm_gap_bubble%0d got %h exp 0", i, obs); end
      n_cmp++;
      tick();
    end
    instr = 8'hA7; instr_valid = 1'b1;
    @(negedge clk);
    if ({imm, Val_Imm, Dest} !== {1'b1, 8'hA7, 2'd2}) begin
      n_mis++; $display("FAIL ldm_gap_emit got %b %h %0d exp 1 a7 2", imm, Val_Imm, Dest);
    end
    n_cmp++;
    tick();
    instr = 8'h1C;                                        // MOV R3,R0 must decode fresh
    @(negedge clk);
    if ({imm, Val_Imm, Dest, WB_EN} !== {1'b0, 8'h00, 2'd3, 1'b1}) begin
      n_mis++; $display("FAIL ldm_back_to_decode got %b %h %0d %b exp 0 00 3 1", imm, Val_Imm, Dest, WB_EN);
    end
    n_cmp++;
    $display("LDM with gap: done");
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_load_use();
    EXE_MEM_R_EN = 1'b1; EXE_Dest = 2'd3; instr = 8'h33; instr_valid = 1'b1;   // SUB R0,R3
    @(negedge clk);
    if ({stall, WB_EN, S, EXE_CMD} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      n_mis++; $display("FAIL lu_stall got st=%b wb=%b s=%b cmd=%0d exp 1 0 0 0", stall, WB_EN, S, EXE_CMD);
    end
    n_cmp++;
    tick();
    EXE_MEM_R_EN = 1'b0;
    @(negedge clk);
    if ({stall, EXE_CMD, Dest, S} !== {1'b0, 4'd2, 2'd0, 1'b1}) begin
      n_mis++; $display("FAIL lu_release got st=%b cmd=%0d d=%0d s=%b exp 0 2 0 1", stall, EXE_CMD, Dest, S);
    end
    n_cmp++;
    tick();
    EXE_MEM_R_EN = 1'b1; instr = 8'h1C;                   // MOV R3,R0 does not read R3
    @(negedge clk);
    if ({stall, WB_EN, Dest, src2} !== {1'b0, 1'b1, 2'd3, 2'd0}) begin
      n_mis++; $display("FAIL lu_no_read got st=%b wb=%b d=%0d s2=%0d exp 0 1 3 0", stall, WB_EN, Dest, src2);
    end
    n_cmp++;
    tick();
    EXE_MEM_R_EN = 1'b0; instr = 8'hCC;                   // ADDI R3
    tick();
    EXE_MEM_R_EN = 1'b1; instr = 8'h0F;
    @(negedge clk);
    if ({stall, EXE_CMD, imm, Val_Imm, Dest, S} !== {1'b0, 4'd1, 1'b1, 8'h0F, 2'd3, 1'b1}) begin
      n_mis++; $display("FAIL lu_imm_nostall got st=%b cmd=%0d imm=%b v=%h d=%0d s=%b exp 0 1 1 0f 3 1",
                        stall, EXE_CMD, imm, Val_Imm, Dest, S);
    end
    n_cmp++;
    $display("load-use: done");
    tick();
    EXE_MEM_R_EN = 1'b0; instr_valid = 1'b0;
  endtask

  task automatic test_bypass();
    logic [7:0] exp_rb;
`ifdef ID_WB_BYPASS_EN
    exp_rb = 8'h3C;
`else
    exp_rb = 8'h11;
`endif
    WB_WB_EN = 1'b1; WB_Dest = 2'd2; WB_Value = 8'h11;
    tick();
    WB_Value = 8'h3C; instr = 8'h82; instr_valid = 1'b1;  // OUT R2
    @(negedge clk);
    if ({outPort, Val_Rb, WB_EN} !== {1'b1, exp_rb, 1'b0}) begin
      n_mis++; $display("FAIL wb_same_cycle got out=%b rb=%h wb=%b exp 1 %h 0", outPort, Val_Rb, WB_EN, exp_rb);
    end
    n_cmp++;
    tick();
    WB_WB_EN = 1'b0;
    @(negedge clk);
    if (Val_Rb !== 8'h3C) begin n_mis++; $display("FAIL wb_next_cycle got %h exp 3c", Val_Rb); end
    n_cmp++;
    $display("OUT R2 with same-cycle WB: Val_Rb=%h", exp_rb);
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset_in_imm();
    instr = 8'hC4; instr_valid = 1'b1;                    // ADDI R1 first word
    tick();
    rst = 1'b1; instr = 8'h12;
    #1;
    @(negedge clk);
    if (obs !== 42'd0) begin n_mis++; $display("FAIL rst_in_imm got %h exp 0", obs); end
    n_cmp++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    if ({WB_EN, Dest, src2, imm, Val_Imm, Val_Rb, EXE_CMD} !== {1'b1, 2'd0, 2'd2, 1'b0, 8'h00, 8'h00, 4'd0}) begin
      n_mis++; $display("FAIL rst_fresh_mov got wb=%b d=%0d s2=%0d imm=%b vi=%h rb=%h cmd=%0d exp 1 0 2 0 00 00 0",
                        WB_EN, Dest, src2, imm, Val_Imm, Val_Rb, EXE_CMD);
    end
    n_cmp++;
    $display("reset in IMM: 0x12 decoded as MOV R0,R2");
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_misc();
    instr = 8'hF5; instr_valid = 1'b1;
    @(negedge clk);
    if (obs !== 42'd0) begin n_mis++; $display("FAIL op15_bubble got %h exp 0", obs); end
    n_cmp++;
    tick();
    in_port = 8'h99; instr = 8'h74;                       // IN R1
    @(negedge clk);
    if ({inPort, Val_Rb, EXE_CMD, Dest, WB_EN} !== {1'b1, 8'h99, 4'd0, 2'd1, 1'b1}) begin
      n_mis++; $display("FAIL in_decode got in=%b rb=%h cmd=%0d d=%0d wb=%b exp 1 99 0 1 1",
                        inPort, Val_Rb, EXE_CMD, Dest, WB_EN);
    end
    n_cmp++;
    tick();
    instr = 8'hA6;                                        // ST R1,R2
    @(negedge clk);
    if ({MEM_W_EN, WB_EN, Dest, EXE_CMD} !== {1'b1, 1'b0, 2'd0, 4'd6}) begin
      n_mis++; $display("FAIL st_decode got mw=%b wb=%b d=%0d cmd=%0d exp 1 0 0 6", MEM_W_EN, WB_EN, Dest, EXE_CMD);
    end
    n_cmp++;
    $display("op15/IN/ST: done");
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr = 8'h00; instr_valid = 1'b0; in_port = 8'h00;
    WB_WB_EN = 1'b0; WB_Dest = 2'd0; WB_Value = 8'h00;
    EXE_MEM_R_EN = 1'b0; EXE_Dest = 2'd0;
    test_reset();
    test_alu();
    test_two_word();
    test_load_use();
    test_bypass();
    test_reset_in_imm();
    test_misc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode stage of the 8-bit pipelined core: accepts one 8-bit instruction word per cycle from IF and owns the 4×8 architectural register file. It drives every `*_in` field of the ID/EX pipeline register and inserts bubbles for two-word immediates and load-use hazards. It also accepts the writeback port from WB.

## Interface
- `REG_W`, default 8: data/register width.
- `clk`  in  1  single core clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr`  in  8  fetched word: opcode[7:4], ra[3:2], rb[1:0]; the second word of a two-word instruction is the immediate.
- `instr_valid`  in  1  `instr` is valid this cycle.
- `in_port`  in  8  external input-port value, passed out as `Val_Rb` for IN.
- `WB_WB_EN`, `WB_Dest[1:0]`, `WB_Value[7:0]`  in  register-file write port.
- `EXE_MEM_R_EN`, `EXE_Dest[1:0]`  in  load currently in EXE, used for load-use detection.
- `WB_EN`, `MEM_R_EN`, `MEM_W_EN`, `S`, `inPort`, `outPort`, `imm`  out  1 each.
- `EXE_CMD`  out  4;  `Val_Ra`, `Val_Rb`, `Val_Imm`  out  8;  `Dest`, `src1`, `src2`  out  2.
- `stall`  out  1  IF must hold `instr` and the PC.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 MOV ra←rb.
  - 2 ADD, 3 SUB, 4 AND, 5 OR: ra←ra op rb, with S=1.
  - 6 NOT ra, with S=1.
  - 7 IN ra←in_port.
  - 8 OUT rb.
  - 9 LD ra←M[rb].
  - 10 ST M[ra]←rb.
  - 11 LDM ra←imm.
  - 12 ADDI ra←ra+imm, with S=1.
  - 13 LDD ra←M[imm].
  - 14 STD M[imm]←rb.
  - 15 reserved, decodes as NOP.
- EXE_CMD codes: 0 PASS_B, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT_A, 6 PASS_A.
- `imm`=1 for opcodes 11–14; the ALU then takes `Val_Imm` in place of `Val_Rb`.
- Field mapping: `src1`=ra, `src2`=rb, `Dest`=ra for writers. `WB_EN`=1 for 1–7, 9, 11–13.
- Bubble: all control outputs are 0, data outputs are 0, `EXE_CMD`=0.
- FSM states:
  - DECODE:
    - No `instr_valid`: bubble.
    - Single-word opcode: emit it.
    - Two-word opcode: latch opcode/ra/rb into hold registers, emit bubble, go to IMM.
  - IMM: on `instr_valid`, emit the held instruction with `Val_Imm`=`instr` and return to DECODE; otherwise bubble and stay.
- Load-use stall:
  - Condition: state is DECODE, `instr_valid`, `EXE_MEM_R_EN`, and `EXE_Dest` equals a source the opcode actually reads.
  - Response: bubble, `stall`=1, state unchanged.
  - No stall in IMM, because the preceding slot was a bubble.
- Register file: write on posedge when `WB_WB_EN`; two asynchronous read ports. `Val_Ra`/`Val_Rb` are read in the emitting cycle.
- Reset: all registers 0, state DECODE, hold registers 0. While `rst` is high all outputs are bubble and `stall`=0.
- Reset asserted while in IMM abandons the held instruction.

## Timing
- All outputs are combinational from state, hold registers, register file and inputs; the ID/EX register captures them at the next posedge.
- Decode latency: one-word instructions 0 cycles. Two-word instructions emit one bubble, then the instruction in the cycle the immediate word is valid.
- A stall lasts exactly while the hazard condition holds, normally 1 cycle.
- A writeback to reg r and a read of r in the same cycle: see Configuration.
- A writeback in the same cycle as an IMM-state emit is treated identically.

## Configuration
- `ID_WB_BYPASS_EN` defined: a read port whose address equals `WB_Dest` while `WB_WB_EN` returns `WB_Value` (write-through).
- Not defined: the read returns the pre-write contents. The compiler must then separate writer and reader by a NOP.

## Structure
- Shared package/header `isa_defs`: opcode constants, EXE_CMD constants, the `REG_W` default, and the two-word opcode set.
- One sub-module `reg_file` (4×8, 1W/2R, bypass under the macro). Decode, FSM and hazard logic live in `id_stage`.

## Test plan
- After reset: `Val_Ra`=0, all outputs 0, `stall`=0. Write R1=0x05 via the WB port, then ADD R1,R1 → `EXE_CMD`=1, `Val_Ra`=`Val_Rb`=0x05, `WB_EN`=1, `S`=1, `Dest`=1.
- LDM R2 then 0xA7 → cycle 0 bubble; cycle 1 `imm`=1, `Val_Imm`=0xA7, `Dest`=2, `WB_EN`=1. A 2-cycle `instr_valid` gap between the words holds IMM and emits bubbles.
- `EXE_MEM_R_EN`=1, `EXE_Dest`=3, then SUB R0,R3 → `stall`=1 and bubble.
  - Next cycle with `EXE_MEM_R_EN`=0 → SUB is emitted.
  - MOV R3,R0 under the same condition → no stall, because R3 is not read.
- Same-cycle WB R2←0x3C and OUT R2:
  - With the macro: `Val_Rb`=0x3C, `outPort`=1.
  - Without the macro: the old R2 value.
- Assert `rst` while in IMM after an ADDI first word → bubble outputs; the next 0x12 word decodes as a fresh MOV R0,R2 rather than as an immediate.
- Opcode 15 and IN R1 with `in_port`=0x99 → opcode 15 gives a bubble; IN gives `inPort`=1, `Val_Rb`=0x99, `EXE_CMD`=0, `Dest`=1.
